// File: rtl/eth_hdr_parser_vlan.sv
// eth_hdr_parser_vlan: AXI-Stream pass-through Ethernet/802.1Q header parser with runt detection and saturating stats
//   clk, rst_n                       : clock, asynchronous active-low reset
//   s_t*  / m_t*                     : input stream and zero-latency pass-through output stream
//   hdr_valid/hdr_ready, hdr_*       : registered parsed header side channel
//   stat_clr, stat_frames/runts/vlan : synchronous clear and saturating counters
module eth_hdr_parser_vlan #(
  parameter int DATA_WIDTH = 64,
  parameter int VLAN_EN    = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    m_tvalid,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output logic [47:0]             hdr_dst_mac,
  output logic [47:0]             hdr_src_mac,
  output logic [15:0]             hdr_eth_type,
  output logic                    hdr_vlan_present,
  output logic [15:0]             hdr_vlan_tci,
  output logic                    hdr_runt,
  input  logic                    stat_clr,
  output logic [CNT_WIDTH-1:0]    stat_frames,
  output logic [CNT_WIDTH-1:0]    stat_runts,
  output logic [CNT_WIDTH-1:0]    stat_vlan
);
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic {HDR, PAYLOAD} state_t;
  state_t       state_q;
  logic [4:0]   offset_q, offset_d;
  logic [143:0] cap_q, cap_d;
  logic [5:0]   sum;
  logic         stall, accept, hdr_acc, vlan_d, complete_d, runt_d, set_d;
  // Hold the first beat of a frame until the previous header has been taken.
  assign stall    = (state_q == HDR) && (offset_q == 5'd0) && hdr_valid && !hdr_ready;
  assign s_tready = m_tready && !stall;
  assign m_tvalid = s_tvalid && !stall;
  assign m_tdata  = s_tdata;
  assign m_tkeep  = s_tkeep;
  assign m_tlast  = s_tlast;
  assign accept   = s_tvalid && s_tready;
  assign hdr_acc  = accept && (state_q == HDR);
  // Header bytes 0..17 live in cap, byte j at [143-8j -: 8]; a new frame starts from all-zero.
  always_comb begin
    cap_d = (offset_q == 5'd0) ? '0 : cap_q;
    sum   = {1'b0, offset_q};
    for (int i = 0; i < NB; i++) begin
      sum = sum + {5'd0, s_tkeep[i]};
      for (int j = 0; j < 18; j++)
        if (s_tkeep[i] && (int'(offset_q) + i == j)) cap_d[143-8*j -: 8] = s_tdata[8*i +: 8];
    end
    offset_d   = (sum > 6'd18) ? 5'd18 : sum[4:0];
    vlan_d     = (VLAN_EN != 0) && (offset_d >= 5'd14) && (cap_d[47:32] == 16'h8100);
    complete_d = hdr_acc && (vlan_d ? (offset_d == 5'd18) : (offset_d >= 5'd14));
    runt_d     = hdr_acc && s_tlast && !complete_d;
    set_d      = complete_d || runt_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= HDR;
      offset_q         <= '0;
      cap_q            <= '0;
      hdr_valid        <= 1'b0;
      hdr_dst_mac      <= '0;
      hdr_src_mac      <= '0;
      hdr_eth_type     <= '0;
      hdr_vlan_present <= 1'b0;
      hdr_vlan_tci     <= '0;
      hdr_runt         <= 1'b0;
      stat_frames      <= '0;
      stat_runts       <= '0;
      stat_vlan        <= '0;
    end else begin
      if (hdr_acc) begin
        cap_q    <= cap_d;
        offset_q <= set_d ? 5'd0 : offset_d;
        state_q  <= (complete_d && !s_tlast) ? PAYLOAD : HDR;
      end else if (accept && s_tlast) begin
        state_q  <= HDR;
      end
      if (set_d) begin
        hdr_dst_mac      <= cap_d[143:96];
        hdr_src_mac      <= cap_d[95:48];
        hdr_eth_type     <= vlan_d ? cap_d[15:0] : cap_d[47:32];
        hdr_vlan_present <= vlan_d;
        hdr_vlan_tci     <= vlan_d ? cap_d[31:16] : 16'h0;
        hdr_runt         <= runt_d;
      end
      hdr_valid   <= set_d || (hdr_valid && !hdr_ready);
      stat_frames <= stat_clr ? '0 : stat_frames + {{(CNT_WIDTH-1){1'b0}}, set_d && !(&stat_frames)};
      stat_runts  <= stat_clr ? '0 : stat_runts + {{(CNT_WIDTH-1){1'b0}}, runt_d && !(&stat_runts)};
      stat_vlan   <= stat_clr ? '0 : stat_vlan + {{(CNT_WIDTH-1){1'b0}}, set_d && vlan_d && !(&stat_vlan)};
    end
  end
endmodule

// File: tb/tb_eth_hdr_parser_vlan.sv
// tb_eth_hdr_parser_vlan: scoreboard bench for eth_hdr_parser_vlan (directed 64-bit table plus random 32/128/64-noVLAN runs)
module tb_eth_hdr_parser_vlan;
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    logic        vp;
    logic [15:0] tci;
    logic        runt;
  } hdr_t;
  typedef struct {
    int          len;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] t12;
    logic [15:0] t14;
    logic [15:0] t16;
    hdr_t        exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stat_clr = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  // Frame-level reference: which header bytes exist decides every field.
  function automatic hdr_t model(input logic [7:0] f [128], input int len, input bit ven);
    logic [7:0] b [18];
    hdr_t m;
    for (int i = 0; i < 18; i++) b[i] = (i < len) ? f[i] : 8'h00;
    m.vp   = ven && len >= 14 && {b[12], b[13]} == 16'h8100;
    m.dst  = {b[0], b[1], b[2], b[3], b[4], b[5]};
    m.src  = {b[6], b[7], b[8], b[9], b[10], b[11]};
    m.et   = m.vp ? {b[16], b[17]} : {b[12], b[13]};
    m.tci  = m.vp ? {b[14], b[15]} : 16'h0;
    m.runt = len < (m.vp ? 18 : 14);
    return m;
  endfunction
  // ---------------- directed 64-bit, VLAN_EN=1 DUT ----------------
  logic s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready, hdr_valid, hdr_ready;
  logic [63:0] s_tdata, m_tdata;
  logic [7:0] s_tkeep, m_tkeep;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_eth_type, hdr_vlan_tci;
  logic hdr_vlan_present, hdr_runt;
  logic [31:0] stat_frames, stat_runts, stat_vlan;
  hdr_t hq[$];
  logic [72:0] sq[$];
  eth_hdr_parser_vlan #(.DATA_WIDTH(64), .VLAN_EN(1), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tready(m_tready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_eth_type(hdr_eth_type), .hdr_vlan_present(hdr_vlan_present), .hdr_vlan_tci(hdr_vlan_tci),
    .hdr_runt(hdr_runt), .stat_clr(stat_clr),
    .stat_frames(stat_frames), .stat_runts(stat_runts), .stat_vlan(stat_vlan)
  );
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        chk("stream beat expected", sq.size() != 0, 1);
        if (sq.size() != 0) chk("stream beat", {m_tdata, m_tkeep, m_tlast}, sq.pop_front());
      end
      if (hdr_valid && hdr_ready) begin
        chk("header expected", hq.size() != 0, 1);
        if (hq.size() != 0)
          chk("header fields", {hdr_dst_mac, hdr_src_mac, hdr_eth_type, hdr_vlan_present, hdr_vlan_tci, hdr_runt}, hq.pop_front());
      end
    end
  end
  task automatic beat64(input logic [63:0] d, input logic [7:0] k, input logic l);
    int w;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    sq.push_back({d, k, l});
    w = 0;
    do begin @(negedge clk); w++; end while (!s_tready && w < 1000);
    if (!s_tready) begin $display("FAIL beat accept timeout"); $fatal(1); end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask
  task automatic beat_of(input logic [7:0] f [128], input int len, input int o);
    logic [63:0] d;
    logic [7:0] k;
    d = '0; k = '0;
    for (int b = 0; b < 8; b++) if (o + b < len) begin d[8*b +: 8] = f[o+b]; k[b] = 1'b1; end
    beat64(d, k, o + 8 >= len);
  endtask
  task automatic send64(input logic [7:0] f [128], input int len, input hdr_t e);
    hq.push_back(e);
    for (int o = 0; o < len; o += 8) beat_of(f, len, o);
  endtask
  task automatic mkf(input vec_t v, output logic [7:0] f [128]);
    for (int i = 0; i < 128; i++) f[i] = 8'(i);
    for (int i = 0; i < 6; i++) begin f[i] = v.dst[47-8*i -: 8]; f[6+i] = v.src[47-8*i -: 8]; end
    {f[12], f[13], f[14], f[15], f[16], f[17]} = {v.t12, v.t14, v.t16};
  endtask
  task automatic drain();
    int w = 0;
    while ((hq.size() != 0 || sq.size() != 0) && w < 1000) begin @(posedge clk); w++; end
    chk("scoreboard drained", {hq.size() == 0, sq.size() == 0}, 2'b11);
    @(posedge clk); #1;
  endtask
  task automatic chk_stats(input string nm, input int fr, input int ru, input int vl);
    chk(nm, {stat_frames, stat_runts, stat_vlan}, {fr[31:0], ru[31:0], vl[31:0]});
  endtask
  // ---------------- random runs: 32-bit, 128-bit, 64-bit with VLAN_EN=0 ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int DW = (g == 0) ? 32 : (g == 1) ? 128 : 64;
    localparam int VE = (g == 2) ? 0 : 1;
    localparam int NB = DW / 8;
    logic tv = 1'b0, tl = 1'b0, tr, mv, ml, mr = 1'b0, hv, hr = 1'b0;
    logic [DW-1:0] td = '0, md;
    logic [NB-1:0] tk = '0, mk;
    logic [47:0] hd, hs;
    logic [15:0] he, ht;
    logic hp, hu;
    logic [31:0] sf, sr, sv;
    hdr_t rq[$];
    logic [DW+NB:0] bq[$];
    int n_runt = 0, n_vlan = 0;
    bit done = 1'b0;
    eth_hdr_parser_vlan #(.DATA_WIDTH(DW), .VLAN_EN(VE), .CNT_WIDTH(32)) u_rnd (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(tv), .s_tdata(td), .s_tkeep(tk), .s_tlast(tl), .s_tready(tr),
      .m_tvalid(mv), .m_tdata(md), .m_tkeep(mk), .m_tlast(ml), .m_tready(mr),
      .hdr_valid(hv), .hdr_ready(hr), .hdr_dst_mac(hd), .hdr_src_mac(hs),
      .hdr_eth_type(he), .hdr_vlan_present(hp), .hdr_vlan_tci(ht),
      .hdr_runt(hu), .stat_clr(stat_clr),
      .stat_frames(sf), .stat_runts(sr), .stat_vlan(sv)
    );
    initial forever begin
      @(posedge clk); #1;
      mr = $urandom_range(0, 3) != 0;
      hr = $urandom_range(0, 1) != 0;
    end
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mv && mr) begin
          chk($sformatf("rnd%0d beat expected", DW), bq.size() != 0, 1);
          if (bq.size() != 0) chk($sformatf("rnd%0d stream", DW), {md, mk, ml}, bq.pop_front());
        end
        if (hv && hr) begin
          chk($sformatf("rnd%0d header expected", DW), rq.size() != 0, 1);
          if (rq.size() != 0) chk($sformatf("rnd%0d header", DW), {hd, hs, he, hp, ht, hu}, rq.pop_front());
        end
      end
    end
    initial begin
      logic [7:0] f [128];
      logic [DW-1:0] d;
      logic [NB-1:0] k;
      hdr_t e;
      int len, w;
      @(posedge rst_n); @(posedge clk); #1;
      for (int fr = 0; fr < 100; fr++) begin
        len = $urandom_range(6, 80);
        for (int i = 0; i < 128; i++) f[i] = 8'($urandom);
        if ($urandom_range(0, 1) != 0) begin f[12] = 8'h81; f[13] = 8'h00; end
        e = model(f, len, VE != 0);
        rq.push_back(e);
        if (e.runt) n_runt++;
        if (e.vp) n_vlan++;
        for (int o = 0; o < len; o += NB) begin
          d = '0; k = '0;
          for (int b = 0; b < NB; b++) if (o + b < len) begin d[8*b +: 8] = f[o+b]; k[b] = 1'b1; end
          tv = 1'b1; td = d; tk = k; tl = (o + NB >= len);
          bq.push_back({d, k, tl});
          w = 0;
          do begin @(negedge clk); w++; end while (!tr && w < 1000);
          if (!tr) begin $display("FAIL rnd%0d accept timeout", DW); $fatal(1); end
          @(posedge clk); #1;
          tv = 1'b0; tl = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      w = 0;
      while ((rq.size() != 0 || bq.size() != 0) && w < 2000) begin @(posedge clk); w++; end
      #1;
      chk($sformatf("rnd%0d drained", DW), {rq.size() == 0, bq.size() == 0}, 2'b11);
      chk($sformatf("rnd%0d stat_frames", DW), sf, 100);
      chk($sformatf("rnd%0d stat_runts", DW), sr, n_runt);
      chk($sformatf("rnd%0d stat_vlan", DW), sv, n_vlan);
      done = 1'b1;
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl [7];
    logic [7:0] f [128];
    logic [7:0] fb [128];
    int w;
    tbl[0] = '{64, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 16'h4500, 16'h0054,
               '{48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 1'b0, 16'h0000, 1'b0}};
    tbl[1] = '{64, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h8100, 16'h6064, 16'h86DD,
               '{48'h001122334455, 48'hAABBCCDDEEFF, 16'h86DD, 1'b1, 16'h6064, 1'b0}};
    tbl[2] = '{10, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 16'h4500, 16'h0054,
               '{48'h001122334455, 48'hAABBCCDD0000, 16'h0000, 1'b0, 16'h0000, 1'b1}};
    tbl[3] = '{14, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h0806, 16'h0001, 16'h0800,
               '{48'h001122334455, 48'hAABBCCDDEEFF, 16'h0806, 1'b0, 16'h0000, 1'b0}};
    tbl[4] = '{16, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h8100, 16'h0005, 16'h0800,
               '{48'h001122334455, 48'hAABBCCDDEEFF, 16'h0000, 1'b1, 16'h0005, 1'b1}};
    tbl[5] = '{18, 48'h001122334455, 48'hAABBCCDDEEFF, 16'h8100, 16'hE00A, 16'h0800,
               '{48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 1'b1, 16'hE00A, 1'b0}};
    tbl[6] = '{23, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88CC, 16'h1234, 16'h5678,
               '{48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88CC, 1'b0, 16'h0000, 1'b0}};
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b1; hdr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset hdr", {hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_eth_type, hdr_vlan_present, hdr_vlan_tci, hdr_runt}, 0);
    chk_stats("reset stats", 0, 0, 0);
    chk("reset s_tready", s_tready, 1);
    chk("reset m_tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && w < 30000) begin @(posedge clk); w++; end
    #1;
    chk("random runs finished", g_rnd[0].done && g_rnd[1].done && g_rnd[2].done, 1);
    for (int i = 0; i < 7; i++) begin
      mkf(tbl[i], f);
      send64(f, tbl[i].len, tbl[i].exp);
    end
    drain();
    chk_stats("table stats", 7, 2, 3);
    // back-to-back frames with the header channel blocked
    hdr_ready = 1'b0;
    mkf(tbl[0], f);
    mkf(tbl[1], fb);
    hq.push_back(tbl[0].exp);
    for (int o = 0; o < 64; o += 8) begin
      beat_of(f, 64, o);
      if (o == 0) chk("no hdr after beat0", hdr_valid, 0);
      if (o == 8) chk("hdr one cycle after beat1", hdr_valid, 1);
    end
    fork
      send64(fb, 64, tbl[1].exp);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall s_tready", s_tready, 0);
          chk("stall m_tvalid", m_tvalid, 0);
          chk("held header", {hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_eth_type, hdr_vlan_present, hdr_vlan_tci, hdr_runt},
              {1'b1, tbl[0].exp});
        end
        @(posedge clk); #1;
        hdr_ready = 1'b1;
        @(negedge clk);
        chk("same-cycle release", s_tready, 1);
      end
    join
    drain();
    chk_stats("b2b stats", 9, 2, 4);
    // reset in the middle of a payload
    mkf(tbl[0], f);
    hq.push_back(tbl[0].exp);
    for (int o = 0; o < 24; o += 8) beat_of(f, 64, o);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset hdr", {hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_eth_type, hdr_vlan_present, hdr_vlan_tci, hdr_runt}, 0);
    chk_stats("midreset stats", 0, 0, 0);
    chk("midreset handshake", {s_tready, m_tvalid}, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mkf(tbl[1], f);
    send64(f, 64, tbl[1].exp);
    drain();
    chk_stats("post-reset stats", 1, 0, 1);
    // clear held across a completing frame
    stat_clr = 1'b1;
    mkf(tbl[3], f);
    send64(f, 14, tbl[3].exp);
    repeat (2) begin @(posedge clk); #1; end
    stat_clr = 1'b0;
    drain();
    chk_stats("clear beats increment", 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_hdr_parser_vlan.md
Name: eth_hdr_parser_vlan

Overview:
- Parametrised successor to the dataplane Ethernet parser. Handles AXI-Stream widths of 32, 64 and 128 bits, optionally decodes an 802.1Q VLAN tag, detects runt frames and keeps saturating statistics.
- Sits on the RX AXI-Stream path. It passes the frame through unchanged and presents the parsed header on a separate valid/ready side channel for downstream lookup logic.

Parameters:
- DATA_WIDTH, 64: stream width in bits. Legal values are 32, 64 and 128.
- VLAN_EN, 1: 1 decodes a TPID of 0x8100. 0 reports 0x8100 as a plain eth_type.
- CNT_WIDTH, 32: width of each statistics counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_tvalid  in  1  input stream valid.
- s_tdata  in  DATA_WIDTH  input data. Byte 0 of each beat is on [7:0].
- s_tkeep  in  DATA_WIDTH/8  byte enables. Low-aligned contiguous; only the tlast beat may be partial.
- s_tlast  in  1  end of frame.
- s_tready  out  1  input ready.
- m_tvalid, m_tdata, m_tkeep, m_tlast  out  1/DATA_WIDTH/DATA_WIDTH/8/1  pass-through stream.
- m_tready  in  1  downstream ready.
- hdr_valid  out  1  parsed header available.
- hdr_ready  in  1  header consumed.
- hdr_dst_mac  out  48  frame bytes 0..5. Byte 0 maps to [47:40].
- hdr_src_mac  out  48  frame bytes 6..11.
- hdr_eth_type  out  16  bytes 12..13, or bytes 16..17 when a VLAN tag is present. The first byte is the MSB.
- hdr_vlan_present  out  1  a VLAN tag was decoded.
- hdr_vlan_tci  out  16  bytes 14..15 when VLAN is present, otherwise 0.
- hdr_runt  out  1  the frame ended before the header was complete.
- stat_clr  in  1  synchronous clear of all counters.
- stat_frames, stat_runts, stat_vlan  out  CNT_WIDTH each  saturating counters.

Behaviour:
- Reset:
  - All hdr_* outputs and counters are 0.
  - State is HDR and the byte offset is 0.
  - s_tready and m_tvalid follow the combinational rule below with stall=0.
  - A reset mid-frame discards the partial frame. The next beat accepted is treated as byte 0.
- Pass-through:
  - m_tdata, m_tkeep and m_tlast equal s_tdata, s_tkeep and s_tlast combinationally.
  - m_tvalid = s_tvalid & ~stall.
  - s_tready = m_tready & ~stall.
  - A beat is accepted when s_tvalid & s_tready.
  - Zero added latency; no data modification.
- Stall:
  - stall = (state==HDR) & (offset==0) & hdr_valid & ~hdr_ready.
  - Effect: the first beat of a new frame is held until the previous header is drained. A same-cycle hdr_ready releases it.
- State machine, states HDR and PAYLOAD:
  - HDR:
    - On each accepted beat, capture the bytes that land in the header offsets 0..13 (or 0..17).
    - offset += popcount(s_tkeep). Offset saturates at 18.
    - The header is complete when offset reaches 14 and bytes 12..13 != 0x8100. If bytes 12..13 == 0x8100 and VLAN_EN=1, completion is at offset 18 instead.
    - On completion without tlast: set hdr_valid on the next edge and go to PAYLOAD.
    - On completion with tlast: set hdr_valid and stay in HDR with offset=0.
  - PAYLOAD: on an accepted tlast beat, return to HDR with offset=0.
- Runt: an accepted tlast beat in HDR before completion produces:
  - hdr_valid=1 and hdr_runt=1;
  - the bytes captured so far, with uncaptured fields 0;
  - hdr_vlan_present=1 only if bytes 12..13==0x8100 were captured and VLAN_EN=1.
- Header channel:
  - Fields are registered. hdr_valid is set the cycle after the completing beat.
  - Fields are stable while hdr_valid=1.
  - hdr_valid clears on hdr_valid & hdr_ready unless a new header completes in the same cycle, in which case it stays 1 with the new fields.
  - At 128 bits a whole 14-byte header completes in one beat. At 32 bits it spans 4 or 5 beats.
- Counters:
  - stat_frames increments on every hdr_valid set event.
  - stat_runts increments on runts.
  - stat_vlan increments when hdr_vlan_present is set.
  - All counters saturate at all-ones.
  - stat_clr has priority over a same-cycle increment, which is lost.

Test Plan:
- 64-bit, VLAN_EN=1, 64-byte frame, dst 0x001122334455, src 0xAABBCCDDEEFF, type 0x0800 -> hdr_valid one cycle after beat 1 with fields exact, vlan_present=0, tci=0, runt=0; m_tdata/m_tkeep/m_tlast equal to s_tdata/s_tkeep/s_tlast every accepted beat; stat_frames=1.
- VLAN frame with TPID 0x8100, TCI 0x6064, inner type 0x86DD -> eth_type=0x86DD, vlan_present=1, tci=0x6064, stat_vlan=1. The same frame with VLAN_EN=0 -> eth_type=0x8100, vlan_present=0.
- 10-byte frame (beat 0 full, beat 1 tkeep=0x03, tlast) -> hdr_runt=1, dst captured, src[15:0]=0, eth_type=0, stat_runts=1.
- Two back-to-back frames with hdr_ready held low -> s_tready=0 on frame 2 beat 0 until hdr_ready=1; frame-1 fields are held throughout; no beat is lost.
- Random m_tready backpressure on 100 frames, DATA_WIDTH=32 and 128 -> output stream identical to input, header fields correct, stat_frames=100.
- rst_n asserted mid-payload, then a clean frame -> all outputs 0 during reset; the clean frame parses correctly. stat_clr pulsed coincident with a completion -> counters read 0.
